seg_scan_capture: RTL and testbench
===================================

# seg_scan_capture

Passive monitor on the multiplexed seven-segment bus. It samples the active-low `anode`/`cathode` scan lines, decodes each digit's segment pattern back to BCD, and publishes a coherent four-digit snapshot once per complete scan frame. It also reports blank and blinking digits. It sits on the stopwatch board beside the display driver, receives the same pins, and feeds self-check logic and the verification scoreboard.

## Interface
- `STABLE_CYCLES`, 4: consecutive identical synchronized samples required before a digit is committed; legal range 2..255.
- `WINDOW_FRAMES`, 64: number of frames in one blink-detection window; legal range 2..65535.
- `clk_sys` input 1: system clock; the only clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `anode` input 4: scan select, active-low one-hot; bit 0 selects digit 0.
- `cathode` input 7: segments, active-low; {a,b,c,d,e,f,g} = bits [6:0].
- `digit_0` to `digit_3` output 4 each: BCD value of each digit from the last complete frame.
- `blank` output 4: digit i was all-segments-off in the last frame.
- `blink` output 4: digit i was both blank and lit within the last completed window.
- `frame_valid` output 1: one-cycle pulse on each snapshot update.
- `seg_err` output 1: one-cycle pulse on an illegal stable pattern.

## Operation
- Sync stage: `anode` and `cathode` each pass through 2 flops. Raw input changes are asynchronous to `clk_sys`.
- Stability counter: resets to 0 when the synchronized {anode, cathode} differs from the previous cycle. Otherwise it increments, saturating at `STABLE_CYCLES`.
- Commit event: occurs exactly once per stable period, in the cycle the counter reaches `STABLE_CYCLES`-1.
- Commit when `anode` is 4'b1111: idle, no action.
- Commit when `anode` is one-hot-low digit i:
  - Cathode decodes to 0..9: the value goes to shadow[i] and shadow blank[i]=0.
  - Cathode is 7'b1111111: shadow value is 0 and blank[i]=1.
  - Any other cathode code: `seg_err` pulses and digit i is not committed.
- Commit when `anode` is not one-hot and not idle: `seg_err` pulses and nothing is committed.
- Decode table (0..9): 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0000100.
- Frame assembly: a seen[3:0] mask bit is set on each commit. When the mask would become 4'b1111:
  - in the same edge, digits and blank load from shadow (including the current commit);
  - `frame_valid` pulses for one cycle;
  - the mask clears.
- Re-committing an already-seen digit before the frame completes overwrites its shadow; the mask is unchanged.
- Blink detection: per digit, the saw_blank and saw_lit flags accumulate on commits. A frame counter counts `frame_valid` pulses. On the `WINDOW_FRAMES`-th pulse:
  - blink[i] is set to saw_blank[i] & saw_lit[i];
  - the flags and the counter clear.
- A commit that coincides with the window end counts toward the closing window.

## Timing
- Reset values: all digits 0, `blank`=4'b1111, `blink`=0, `frame_valid`=0, `seg_err`=0. Internal state is also cleared: mask, counters, and shadow.
- Latency: a pin change that then holds steady commits `STABLE_CYCLES`+2 cycles after the first clock edge that samples it. Example: `STABLE_CYCLES`=4 gives 6 cycles.
- The final commit of a frame and the output update happen in the same cycle.
- `seg_err` and `frame_valid` are each registered and last one cycle. They can never both be asserted in the same cycle.
- A pattern held longer than `STABLE_CYCLES` commits only once.
- A glitch shorter than `STABLE_CYCLES` samples never commits.
- Reset asserted mid-frame: all state clears at once. The first `frame_valid` after release requires all four digits to be freshly committed.

## Structure
- Package `seg_pkg` holds:
  - segment code constants for 0..9 and blank;
  - anode one-hot constants;
  - a pure `seg_decode` function returning {valid, blank, bcd[3:0]}.
- Sub-module `seg_sync_filter` holds the 2-flop synchronizers, the stability counter, and the commit strobe. It outputs `commit`, `an_s`, and `cat_s`.
- Top level holds: decode, shadow/mask, frame publish, and blink window.

## Test plan
- `STABLE_CYCLES`=4. Scan digits 0..3 showing 1,2,3,4, each held 8 cycles.
  - Response: a single `frame_valid` in the 6th cycle after digit 3 appears.
  - `digit_0`..`digit_3` = 1,2,3,4; `blank`=0.
- Hold digit 2 with cathode 7'b1111111 during a full scan.
  - Response: `blank`=4'b0100 and `digit_2`=0.
- Apply cathode 7'b1010101 on digit 1 stable for 4 cycles.
  - Response: one `seg_err` pulse.
  - Frame completes only after a legal digit 1 arrives.
- 3-cycle glitch of `anode`=4'b0011 between legal digits.
  - Response: no `seg_err`, no commit, outputs unchanged.
- `WINDOW_FRAMES`=4. Digit 3 alternates blank/"8" every frame.
  - Response: after the 4th `frame_valid`, `blink`=4'b1000.
  - Steady thereafter, the next window clears it to 0.
- Assert `rst_n` low after 2 digits are committed, then release and scan 4 digits.
  - Response: exactly one `frame_valid`, containing only post-reset values.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants and the segment decoder for the seven-segment scan monitor.
// Segment codes are active-low {a,b,c,d,e,f,g}; anode selects are active-low one-hot.
package seg_pkg;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] AN_IDLE = 4'b1111;
    localparam logic [3:0] AN_D0   = 4'b1110;
    localparam logic [3:0] AN_D1   = 4'b1101;
    localparam logic [3:0] AN_D2   = 4'b1011;
    localparam logic [3:0] AN_D3   = 4'b0111;

    typedef struct packed {
        logic       valid;
        logic       blank;
        logic [3:0] bcd;
    } seg_dec_t;

    // A blank pattern is legal and reads back as value 0 with the blank flag set.
    function automatic seg_dec_t seg_decode(input logic [6:0] cat);
        seg_dec_t r;
        r.valid = 1'b1;
        r.blank = 1'b0;
        r.bcd   = 4'd0;
        case (cat)
            SEG_0:     r.bcd = 4'd0;
            SEG_1:     r.bcd = 4'd1;
            SEG_2:     r.bcd = 4'd2;
            SEG_3:     r.bcd = 4'd3;
            SEG_4:     r.bcd = 4'd4;
            SEG_5:     r.bcd = 4'd5;
            SEG_6:     r.bcd = 4'd6;
            SEG_7:     r.bcd = 4'd7;
            SEG_8:     r.bcd = 4'd8;
            SEG_9:     r.bcd = 4'd9;
            SEG_BLANK: r.blank = 1'b1;
            default:   r.valid = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seg_scan_capture_if.sv
// Display scan bus as seen by the monitor: the raw scan pins plus the decoded snapshot.
// The master side drives the pins; the slave side is the capture monitor.
interface seg_scan_capture_if;

    logic [3:0] anode;
    logic [6:0] cathode;
    logic [3:0] digit_0;
    logic [3:0] digit_1;
    logic [3:0] digit_2;
    logic [3:0] digit_3;
    logic [3:0] blank;
    logic [3:0] blink;
    logic       frame_valid;
    logic       seg_err;

    modport master (
        output anode, cathode,
        input  digit_0, digit_1, digit_2, digit_3, blank, blink, frame_valid, seg_err
    );

    modport slave (
        input  anode, cathode,
        output digit_0, digit_1, digit_2, digit_3, blank, blink, frame_valid, seg_err
    );

endinterface

// File: rtl/seg_sync_filter.sv
// Synchronizes the scan pins and emits one commit strobe per stable period.
// an_s/cat_s hold the last sample, which is the stable pattern whenever commit is high.
module seg_sync_filter
    import seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk_sys,
    input  logic       rst_n,
    input  logic [3:0] anode,
    input  logic [6:0] cathode,
    output logic       commit,
    output logic [3:0] an_s,
    output logic [6:0] cat_s
);

    localparam int             CW         = 8;
    localparam logic [CW-1:0]  CNT_MAX    = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0]  CNT_COMMIT = CW'(STABLE_CYCLES - 1);

    logic [10:0]   meta_q, meta_d;
    logic [10:0]   sync_q, sync_d;
    logic [10:0]   prev_q, prev_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Counter saturates so a long hold passes through CNT_COMMIT exactly once.
    always_comb begin
        meta_d = {anode, cathode};
        sync_d = meta_q;
        prev_d = sync_q;
        cnt_d  = cnt_q;
        if (sync_q != prev_q) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= {AN_IDLE, SEG_BLANK};
            sync_q <= {AN_IDLE, SEG_BLANK};
            prev_q <= {AN_IDLE, SEG_BLANK};
            cnt_q  <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
            cnt_q  <= cnt_d;
        end
    end

    assign commit = (cnt_q == CNT_COMMIT);
    assign an_s   = prev_q[10:7];
    assign cat_s  = prev_q[6:0];

endmodule

// File: rtl/seg_scan_capture.sv
// Passive seven-segment scan monitor: decodes committed digits into a shadow frame,
// publishes the four-digit snapshot once per full scan and tracks blinking digits.
module seg_scan_capture
    import seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int WINDOW_FRAMES = 64
) (
    input  logic                clk_sys,
    input  logic                rst_n,
    seg_scan_capture_if.slave   bus
);

    localparam logic [15:0] WIN_LAST = 16'(WINDOW_FRAMES - 1);

    logic       commit;
    logic [3:0] an_s;
    logic [6:0] cat_s;
    seg_dec_t   dec;
    logic [3:0] dig_sel;

    logic [3:0][3:0] shadow_q, shadow_d;
    logic [3:0]      shadow_blank_q, shadow_blank_d;
    logic [3:0]      seen_q, seen_d;
    logic [3:0][3:0] digit_q, digit_d;
    logic [3:0]      blank_q, blank_d;
    logic [3:0]      blink_q, blink_d;
    logic [3:0]      saw_blank_q, saw_blank_d;
    logic [3:0]      saw_lit_q, saw_lit_d;
    logic [15:0]     frame_cnt_q, frame_cnt_d;
    logic            frame_valid_q, frame_valid_d;
    logic            seg_err_q, seg_err_d;

    seg_sync_filter #(
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .anode   (bus.anode),
        .cathode (bus.cathode),
        .commit  (commit),
        .an_s    (an_s),
        .cat_s   (cat_s)
    );

    always_comb begin
        dec     = seg_decode(cat_s);
        dig_sel = 4'b0000;
        case (an_s)
            AN_D0:   dig_sel = 4'b0001;
            AN_D1:   dig_sel = 4'b0010;
            AN_D2:   dig_sel = 4'b0100;
            AN_D3:   dig_sel = 4'b1000;
            default: dig_sel = 4'b0000;
        endcase
    end

    // The frame-closing commit is folded into the published snapshot and the blink window.
    always_comb begin
        shadow_d       = shadow_q;
        shadow_blank_d = shadow_blank_q;
        seen_d         = seen_q;
        digit_d        = digit_q;
        blank_d        = blank_q;
        blink_d        = blink_q;
        saw_blank_d    = saw_blank_q;
        saw_lit_d      = saw_lit_q;
        frame_cnt_d    = frame_cnt_q;
        frame_valid_d  = 1'b0;
        seg_err_d      = 1'b0;

        if (commit) begin
            if (dig_sel != 4'b0000) begin
                if (dec.valid) begin
                    for (int i = 0; i < 4; i++) begin
                        if (dig_sel[i]) begin
                            shadow_d[i]       = dec.bcd;
                            shadow_blank_d[i] = dec.blank;
                            saw_blank_d[i]    = saw_blank_q[i] | dec.blank;
                            saw_lit_d[i]      = saw_lit_q[i] | ~dec.blank;
                        end
                    end
                    seen_d = seen_q | dig_sel;
                end else begin
                    seg_err_d = 1'b1;
                end
            end else if (an_s != AN_IDLE) begin
                seg_err_d = 1'b1;
            end
        end

        if (seen_d == 4'b1111) begin
            digit_d       = shadow_d;
            blank_d       = shadow_blank_d;
            frame_valid_d = 1'b1;
            seen_d        = 4'b0000;
            if (frame_cnt_q == WIN_LAST) begin
                blink_d     = saw_blank_d & saw_lit_d;
                saw_blank_d = 4'b0000;
                saw_lit_d   = 4'b0000;
                frame_cnt_d = '0;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q       <= '0;
            shadow_blank_q <= 4'b1111;
            seen_q         <= 4'b0000;
            digit_q        <= '0;
            blank_q        <= 4'b1111;
            blink_q        <= 4'b0000;
            saw_blank_q    <= 4'b0000;
            saw_lit_q      <= 4'b0000;
            frame_cnt_q    <= '0;
            frame_valid_q  <= 1'b0;
            seg_err_q      <= 1'b0;
        end else begin
            shadow_q       <= shadow_d;
            shadow_blank_q <= shadow_blank_d;
            seen_q         <= seen_d;
            digit_q        <= digit_d;
            blank_q        <= blank_d;
            blink_q        <= blink_d;
            saw_blank_q    <= saw_blank_d;
            saw_lit_q      <= saw_lit_d;
            frame_cnt_q    <= frame_cnt_d;
            frame_valid_q  <= frame_valid_d;
            seg_err_q      <= seg_err_d;
        end
    end

    assign bus.digit_0     = digit_q[0];
    assign bus.digit_1     = digit_q[1];
    assign bus.digit_2     = digit_q[2];
    assign bus.digit_3     = digit_q[3];
    assign bus.blank       = blank_q;
    assign bus.blink       = blink_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.seg_err     = seg_err_q;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Bench for seg_scan_capture: directed scans plus random pin segments, scored every
// cycle against a segment-level model that schedules each commit from the pin hold time.
module tb_seg_scan_capture;

    localparam int STABLE = 4;
    localparam int WINDOW = 4;

    typedef struct {
        int         edge_no;
        logic [3:0] an;
        logic [6:0] cat;
    } commit_ev_t;

    logic clk_sys = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   fv_seen = 0;
    int   err_seen = 0;
    int   fv0, err0;

    logic [6:0]  seg_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                  7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
    logic [10:0] last_pat;
    commit_ev_t  evq [$];

    int m_shadow [4];
    bit m_sblank [4];
    bit m_seen [4];
    int m_digit [4];
    bit m_blank [4];
    bit m_blink [4];
    bit m_sawb [4];
    bit m_sawl [4];
    int m_frames;
    bit exp_fv, exp_err;

    always #5 clk_sys = ~clk_sys;

    seg_scan_capture_if bus ();

    seg_scan_capture #(
        .STABLE_CYCLES (STABLE),
        .WINDOW_FRAMES (WINDOW)
    ) dut (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", tag, cyc, actual, expected);
        end
    endtask

    function automatic logic [6:0] segCode(input int v);
        if (v > 9) return 7'b1111111;
        return seg_tab[v];
    endfunction

    task automatic modelReset();
        for (int k = 0; k < 4; k++) begin
            m_shadow[k] = 0;
            m_sblank[k] = 1'b1;
            m_seen[k]   = 1'b0;
            m_digit[k]  = 0;
            m_blank[k]  = 1'b1;
            m_blink[k]  = 1'b0;
            m_sawb[k]   = 1'b0;
            m_sawl[k]   = 1'b0;
        end
        m_frames = 0;
        exp_fv   = 1'b0;
        exp_err  = 1'b0;
    endtask

    task automatic modelCommit(input logic [3:0] an, input logic [6:0] cat);
        int idx, val;
        bit legal, is_blank;
        if (an == 4'b1111) return;
        if ($countones(an) != 3) begin
            exp_err = 1'b1;
            return;
        end
        idx = 0;
        for (int k = 0; k < 4; k++) if (!an[k]) idx = k;
        legal = 1'b0;
        is_blank = 1'b0;
        val = 0;
        if (cat == 7'b1111111) begin
            legal = 1'b1;
            is_blank = 1'b1;
        end else begin
            for (int k = 0; k < 10; k++) if (seg_tab[k] == cat) begin legal = 1'b1; val = k; end
        end
        if (!legal) begin
            exp_err = 1'b1;
            return;
        end
        m_shadow[idx] = val;
        m_sblank[idx] = is_blank;
        if (is_blank) m_sawb[idx] = 1'b1; else m_sawl[idx] = 1'b1;
        m_seen[idx] = 1'b1;
        if (m_seen[0] && m_seen[1] && m_seen[2] && m_seen[3]) begin
            exp_fv = 1'b1;
            m_frames++;
            for (int k = 0; k < 4; k++) begin
                m_digit[k] = m_shadow[k];
                m_blank[k] = m_sblank[k];
                m_seen[k]  = 1'b0;
            end
            if (m_frames == WINDOW) begin
                m_frames = 0;
                for (int k = 0; k < 4; k++) begin
                    m_blink[k] = m_sawb[k] & m_sawl[k];
                    m_sawb[k]  = 1'b0;
                    m_sawl[k]  = 1'b0;
                end
            end
        end
    endtask

    function automatic logic [31:0] expSnapshot();
        logic [31:0] v;
        v = '0;
        for (int k = 0; k < 4; k++) begin
            v[4*k +: 4] = 4'(m_digit[k]);
            v[16+k]     = m_blank[k];
            v[20+k]     = m_blink[k];
        end
        v[24] = exp_fv;
        v[25] = exp_err;
        return v;
    endfunction

    // Every edge: retire commits due now, then compare the whole snapshot just after the edge.
    always @(posedge clk_sys) begin
        commit_ev_t ev;
        cyc = cyc + 1;
        exp_fv  = 1'b0;
        exp_err = 1'b0;
        if (rst_n) begin
            while (evq.size() > 0 && evq[0].edge_no <= cyc) begin
                ev = evq.pop_front();
                modelCommit(ev.an, ev.cat);
            end
        end
        #1;
        checkOutput("snapshot",
                    {6'b0, bus.seg_err, bus.frame_valid, bus.blink, bus.blank,
                     bus.digit_3, bus.digit_2, bus.digit_1, bus.digit_0},
                    expSnapshot());
        if (bus.frame_valid) fv_seen++;
        if (bus.seg_err) err_seen++;
    end

    // Called at a falling edge; the pattern is first sampled by the next rising edge.
    task automatic applyStimulus(input logic [3:0] an, input logic [6:0] cat, input int n);
        commit_ev_t ev;
        bus.anode   = an;
        bus.cathode = cat;
        last_pat    = {an, cat};
        if (n >= STABLE) begin
            ev.edge_no = cyc + 1 + STABLE + 2;
            ev.an      = an;
            ev.cat     = cat;
            evq.push_back(ev);
        end
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic scanFrame(input int v0, input int v1, input int v2, input int v3);
        int vals [4];
        logic [3:0] an;
        vals = '{v0, v1, v2, v3};
        for (int i = 0; i < 4; i++) begin
            an = ~(4'b0001 << i);
            applyStimulus(an, segCode(vals[i]), 8);
        end
    endtask

    task automatic doReset();
        rst_n       = 1'b0;
        bus.anode   = 4'b1111;
        bus.cathode = 7'b1111111;
        last_pat    = {4'b1111, 7'b1111111};
        evq.delete();
        modelReset();
        repeat (3) @(negedge clk_sys);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_sys);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: bench did not finish by cycle %0d, required completion", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] an;
        logic [6:0] cat;
        int n;

        rst_n       = 1'b0;
        bus.anode   = 4'b1111;
        bus.cathode = 7'b1111111;
        last_pat    = {4'b1111, 7'b1111111};
        modelReset();
        repeat (3) @(negedge clk_sys);
        checkOutput("reset_blank", 32'(bus.blank), 32'h0000000F);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_sys);

        $display("[TB] basic scan 1,2,3,4");
        fv0 = fv_seen;
        scanFrame(1, 2, 3, 4);
        checkOutput("scan_digits", {16'b0, bus.digit_3, bus.digit_2, bus.digit_1, bus.digit_0}, 32'h00004321);
        checkOutput("scan_blank", 32'(bus.blank), 32'h0);
        checkOutput("scan_fv_count", 32'(fv_seen - fv0), 32'd1);

        $display("[TB] blank digit 2");
        scanFrame(5, 6, 15, 7);
        checkOutput("blank_mask", 32'(bus.blank), 32'h4);
        checkOutput("blank_digit2", 32'(bus.digit_2), 32'h0);

        $display("[TB] illegal cathode on digit 1");
        fv0  = fv_seen;
        err0 = err_seen;
        applyStimulus(4'b1110, segCode(1), 8);
        applyStimulus(4'b1101, 7'b1010101, 4);
        applyStimulus(4'b1011, segCode(3), 8);
        applyStimulus(4'b0111, segCode(4), 8);
        checkOutput("illegal_err_count", 32'(err_seen - err0), 32'd1);
        checkOutput("illegal_no_frame", 32'(fv_seen - fv0), 32'd0);
        applyStimulus(4'b1101, segCode(2), 8);
        checkOutput("illegal_late_frame", 32'(fv_seen - fv0), 32'd1);
        checkOutput("illegal_digits", {16'b0, bus.digit_3, bus.digit_2, bus.digit_1, bus.digit_0}, 32'h00004321);

        $display("[TB] short anode glitch");
        fv0  = fv_seen;
        err0 = err_seen;
        applyStimulus(4'b1110, segCode(9), 8);
        applyStimulus(4'b0011, segCode(0), 3);
        applyStimulus(4'b1101, segCode(8), 8);
        checkOutput("glitch_no_err", 32'(err_seen - err0), 32'd0);
        checkOutput("glitch_no_frame", 32'(fv_seen - fv0), 32'd0);
        checkOutput("glitch_digits", {16'b0, bus.digit_3, bus.digit_2, bus.digit_1, bus.digit_0}, 32'h00004321);

        $display("[TB] blink window");
        doReset();
        fv0 = fv_seen;
        for (int f = 0; f < 4; f++) scanFrame(1, 2, 3, (f % 2 == 0) ? 15 : 8);
        checkOutput("blink_frames", 32'(fv_seen - fv0), 32'd4);
        checkOutput("blink_set", 32'(bus.blink), 32'h8);
        for (int f = 0; f < 3; f++) scanFrame(1, 2, 3, 8);
        checkOutput("blink_hold", 32'(bus.blink), 32'h8);
        scanFrame(1, 2, 3, 8);
        checkOutput("blink_clear", 32'(bus.blink), 32'h0);

        $display("[TB] reset mid-frame");
        applyStimulus(4'b1110, segCode(1), 8);
        applyStimulus(4'b1101, segCode(2), 8);
        doReset();
        checkOutput("midreset_digits", {16'b0, bus.digit_3, bus.digit_2, bus.digit_1, bus.digit_0}, 32'h0);
        fv0 = fv_seen;
        scanFrame(5, 6, 7, 8);
        checkOutput("midreset_fv_count", 32'(fv_seen - fv0), 32'd1);
        checkOutput("midreset_digits_new", {16'b0, bus.digit_3, bus.digit_2, bus.digit_1, bus.digit_0}, 32'h00008765);
        checkOutput("midreset_blank", 32'(bus.blank), 32'h0);

        $display("[TB] random segments");
        for (int s = 0; s < 400; s++) begin
            do begin
                n = int'($urandom_range(0, 9));
                if (n < 7) begin
                    an = ~(4'b0001 << $urandom_range(0, 3));
                end else if (n < 8) begin
                    an = 4'b1111;
                end else begin
                    do an = 4'($urandom()); while ($countones(an) > 2);
                end
                n = int'($urandom_range(0, 19));
                if (n < 14) cat = segCode(int'($urandom_range(0, 9)));
                else if (n < 17) cat = 7'b1111111;
                else cat = 7'($urandom());
            end while ({an, cat} == last_pat);
            applyStimulus(an, cat, int'($urandom_range(1, 10)));
        end
        applyStimulus((last_pat[10:7] == 4'b1111) ? 4'b1110 : 4'b1111, 7'b1111111, 10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
